// File: rtl/core7_pio_pkg.sv
// -----------------------------------------------------------------------------
// core7_pio_pkg
// Shared constants for the core7 LED PIO slice:
//   - word addresses of the Avalon-MM register map
//   - width of the blink prescaler / down-counter
//   - prescale_t type and a zero-extension helper for the read mux
// -----------------------------------------------------------------------------
package core7_pio_pkg;

  localparam int PRESCALE_W = 26;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK    = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  typedef logic [PRESCALE_W-1:0] prescale_t;

  // Zero-extend a prescale value onto the 32-bit read bus.
  function automatic logic [31:0] zext_prescale(input prescale_t value);
    zext_prescale = {6'd0, value};
  endfunction

endpackage

// File: rtl/core7_blink_timer.sv
// -----------------------------------------------------------------------------
// core7_blink_timer
// 26-bit down-counter that toggles a blink phase each time it expires.
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset (counter = RESET_VALUE, phase = 0)
//   load       : restart request; counter <= load_value, phase <= 0
//   load_value : value used both for an explicit load and for the reload on
//                expiry (the parent presents the live PRESCALE here when not
//                loading)
//   phase      : current blink phase
// -----------------------------------------------------------------------------
module core7_blink_timer
  import core7_pio_pkg::*;
#(
  parameter prescale_t RESET_VALUE = 26'd25000000
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load,
  input  prescale_t load_value,
  output logic      phase
);

  prescale_t count_r;
  prescale_t count_nxt_s;
  logic      phase_r;
  logic      phase_nxt_s;

  // Next count/phase: an explicit load wins over a coincident expiry.
  always_comb begin
    count_nxt_s = count_r - 26'd1;
    phase_nxt_s = phase_r;
    if (load) begin
      count_nxt_s = load_value;
      phase_nxt_s = 1'b0;
    end else if (count_r == 26'd0) begin
      // A zero prescale lands here every cycle, so phase toggles each clock.
      count_nxt_s = load_value;
      phase_nxt_s = ~phase_r;
    end else begin
      count_nxt_s = count_r - 26'd1;
      phase_nxt_s = phase_r;
    end
  end

  // Counter and phase state; reset aborts any count in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= RESET_VALUE;
      phase_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      phase_r <= phase_nxt_s;
    end
  end

  assign phase = phase_r;

endmodule

// File: rtl/core7_led_pio.sv
// -----------------------------------------------------------------------------
// core7_led_pio
// Avalon-MM LED output port with set/clear aliases and a hardware blinker.
// Ports:
//   clk, reset_n : clock (rising edge) and asynchronous active-low reset
//   chipselect   : slave select; qualifies write
//   address[2:0] : word address (0 DATA, 1 BLINK, 2 PRESCALE, 3 STATUS,
//                  4 OUTSET, 5 OUTCLEAR, 6-7 reserved)
//   write        : write strobe
//   writedata    : write data; bits above a register's width are dropped
//   readdata     : registered read data, refreshed every clock from address
//   out_port     : DATA ^ (BLINK & phase), built from registers only
// -----------------------------------------------------------------------------
module core7_led_pio
  import core7_pio_pkg::*;
#(
  parameter int        WIDTH          = 18,
  parameter prescale_t PRESCALE_RESET = 26'd25000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [2:0]       address,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] blink_r;
  prescale_t        prescale_r;
  logic [31:0]      readdata_r;

  logic [WIDTH-1:0] data_nxt_s;
  logic [WIDTH-1:0] blink_nxt_s;
  prescale_t        prescale_nxt_s;
  logic [31:0]      readdata_nxt_s;

  logic             wr_en_s;
  logic [WIDTH-1:0] wdata_s;
  logic             timer_load_s;
  prescale_t        timer_value_s;
  logic             phase_s;
  logic             unused_wdata_s;

  assign wr_en_s = chipselect & write;
  assign wdata_s = writedata[WIDTH-1:0];

  // Upper writedata bits are intentionally dropped for narrow registers.
  assign unused_wdata_s = ^writedata;

  // Register write decode; STATUS and reserved addresses fall to default.
  always_comb begin
    data_nxt_s     = data_r;
    blink_nxt_s    = blink_r;
    prescale_nxt_s = prescale_r;
    if (wr_en_s) begin
      case (address)
        ADDR_DATA:     data_nxt_s     = wdata_s;
        ADDR_BLINK:    blink_nxt_s    = wdata_s;
        ADDR_PRESCALE: prescale_nxt_s = writedata[PRESCALE_W-1:0];
        ADDR_OUTSET:   data_nxt_s     = data_r | wdata_s;
        ADDR_OUTCLEAR: data_nxt_s     = data_r & ~wdata_s;
        default:       data_nxt_s     = data_r;
      endcase
    end else begin
      data_nxt_s = data_r;
    end
  end

  // Timer restart on a PRESCALE write; otherwise it reloads from PRESCALE.
  always_comb begin
    timer_load_s  = 1'b0;
    timer_value_s = prescale_r;
    if (wr_en_s && (address == ADDR_PRESCALE)) begin
      timer_load_s  = 1'b1;
      timer_value_s = writedata[PRESCALE_W-1:0];
    end else begin
      timer_load_s  = 1'b0;
      timer_value_s = prescale_r;
    end
  end

  // Read mux on pre-edge register values; unmapped addresses read zero.
  always_comb begin
    readdata_nxt_s = 32'd0;
    case (address)
      ADDR_DATA:     readdata_nxt_s[WIDTH-1:0] = data_r;
      ADDR_BLINK:    readdata_nxt_s[WIDTH-1:0] = blink_r;
      ADDR_PRESCALE: readdata_nxt_s            = zext_prescale(prescale_r);
      ADDR_STATUS:   readdata_nxt_s[0]         = phase_s;
      default:       readdata_nxt_s            = 32'd0;
    endcase
  end

  // Bus-visible registers and the read data pipeline stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_r     <= '0;
      blink_r    <= '0;
      prescale_r <= PRESCALE_RESET;
      readdata_r <= 32'd0;
    end else begin
      data_r     <= data_nxt_s;
      blink_r    <= blink_nxt_s;
      prescale_r <= prescale_nxt_s;
      readdata_r <= readdata_nxt_s;
    end
  end

  core7_blink_timer #(
    .RESET_VALUE (PRESCALE_RESET)
  ) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load_s),
    .load_value (timer_value_s),
    .phase      (phase_s)
  );

  assign readdata = readdata_r;
  assign out_port = data_r ^ (blink_r & {WIDTH{phase_s}});

endmodule

// File: doc/core7_led_pio.md
CORE7_LED_PIO -- requirements
Module: core7_led_pio

Interface
REQ-001 SHALL have parameter WIDTH, default 18: output port width, 1..32.
REQ-002 SHALL have parameter PRESCALE_RESET, default 25000000: reset value of PRESCALE, 26-bit.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port chipselect  input  1  Avalon-MM slave select.
REQ-006 SHALL have port address  input  3  word address.
REQ-007 SHALL have port write  input  1  write strobe, qualified by chipselect.
REQ-008 SHALL have port writedata  input  32  write data.
REQ-009 SHALL have port readdata  output  32  registered read data.
REQ-010 SHALL have port out_port  output  WIDTH  driven to LEDs.

Function
REQ-011 SHALL implement this register map:
- 0 DATA, rw, WIDTH bits
- 1 BLINK mask, rw, WIDTH bits
- 2 PRESCALE, rw, 26 bits
- 3 STATUS, ro, bit0 = phase
- 4 OUTSET, wo
- 5 OUTCLEAR, wo
- 6, 7 reserved
REQ-012 SHALL perform a write only when chipselect=1 and write=1 at a rising edge; the new value is visible from that edge.
REQ-013 SHALL ignore writedata bits above the register width.
REQ-014 SHALL, on a write to OUTSET, set DATA <= DATA | writedata[WIDTH-1:0].
REQ-015 SHALL, on a write to OUTCLEAR, set DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 SHALL ignore writes to STATUS and to the reserved addresses.
REQ-017 SHALL update readdata every clock from the current address, independent of read/chipselect: read latency 1, zero wait states.
REQ-018 SHALL zero-extend readdata; addresses 4-7 SHALL read 0.
REQ-019 SHALL run a 26-bit down-counter:
- loaded with PRESCALE on reset and on each expiry
- decrements each cycle
- at count 0: toggles phase and reloads PRESCALE
REQ-020 SHALL, when PRESCALE=0, toggle phase every cycle.
REQ-021 SHALL, on a PRESCALE write, load the counter with the new value and clear phase at that edge; this write SHALL take priority over a coincident expiry.
REQ-022 SHALL drive out_port = DATA ^ (BLINK & {WIDTH{phase}}) from registers only, with no combinational path from bus inputs.
REQ-023 SHALL leave the counter and phase unchanged by DATA, BLINK, OUTSET and OUTCLEAR writes.

Reset
REQ-024 SHALL, while reset_n=0, asynchronously force:
- DATA = 0, BLINK = 0, PRESCALE = PRESCALE_RESET
- counter = PRESCALE_RESET, phase = 0
- readdata = 0, out_port = 0
REQ-025 SHALL release reset synchronously to clk; an assertion mid-blink SHALL abort the count with no residual state.

Structure
REQ-026 SHALL take the register address constants (ADDR_DATA ... ADDR_OUTCLEAR) and the 26-bit prescale width from the shared package core7_pio_pkg.
REQ-027 SHALL place the counter and phase in one sub-module, core7_blink_timer, with ports:
- clk, reset_n
- load, load_value
- phase
REQ-028 SHALL stay within 120-400 lines of RTL in total.

Verification
REQ-029 SHALL cover: reset, then write DATA=0x2A5A5 -> out_port=0x2A5A5 from the next cycle; address 0 then reads 0x0002A5A5 one cycle later.
REQ-030 SHALL cover: DATA=0x00F0F, OUTSET 0x30000, then OUTCLEAR 0x0000F -> DATA=0x30F00; address 4 reads 0.
REQ-031 SHALL cover: PRESCALE=3, BLINK=0x00001, DATA=0 -> out_port bit0 toggles every 4 cycles; STATUS bit0 tracks phase.
REQ-032 SHALL cover: PRESCALE write on the same cycle the counter expires -> phase=0 and the counter reloads with the new value.
REQ-033 SHALL cover: write with chipselect=0 -> no register changes; PRESCALE=0 -> phase toggles every cycle.
REQ-034 SHALL cover: reset_n asserted mid-blink -> all outputs 0 immediately, and the first toggle after release occurs PRESCALE_RESET+1 cycles later.
